// File: rtl/elut_bank_if.sv
// Configuration handshake and LUT read/output bundle for elut_bank.
// The bank drives the slave side; the configuring agent drives the master side.
interface elut_bank_if #(
  parameter int K        = 6,
  parameter int NUM_LUTS = 8,
  parameter int CFG_W    = 8
);
  logic                  cfg_start;
  logic [CFG_W-1:0]      cfg_data;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic                  cfg_busy;
  logic                  cfg_done;
  logic [NUM_LUTS*K-1:0] rd_addr;
  logic [NUM_LUTS-1:0]   lut_comb;
  logic [NUM_LUTS-1:0]   lut_reg;
  logic [NUM_LUTS-1:0]   lut_out;

  modport master (
    output cfg_start, cfg_data, cfg_valid, rd_addr,
    input  cfg_ready, cfg_busy, cfg_done, lut_comb, lut_reg, lut_out
  );

  modport slave (
    input  cfg_start, cfg_data, cfg_valid, rd_addr,
    output cfg_ready, cfg_busy, cfg_done, lut_comb, lut_reg, lut_out
  );
endinterface

// File: rtl/elut_bank.sv
// Bank of NUM_LUTS K-input LUTs loaded by a serial beat stream; each LUT takes
// 2**K/CFG_W mask beats followed by one mode beat selecting registered or combinational output.
module elut_bank #(
  parameter int K        = 6,
  parameter int NUM_LUTS = 8,
  parameter int CFG_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  elut_bank_if.slave bus
);

  localparam int DEPTH = 2**K;
  localparam int B     = DEPTH / CFG_W;
  localparam int BW    = $clog2(B + 1);
  localparam int LW    = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [LW-1:0]       lut_q, lut_d;
  logic [NUM_LUTS-1:0] mode_q, mode_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [NUM_LUTS-1:0] lut_reg_q, lut_reg_d;
  logic [NUM_LUTS-1:0] lut_comb_w;
  logic                mask_we;

  // Mask RAM: deliberately unreset; outputs are gated until a full load completes.
  logic [DEPTH-1:0]    mask_q [NUM_LUTS];

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    lut_d   = lut_q;
    mode_d  = mode_q;
    mask_we = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.cfg_start) begin
          state_d = S_LOAD;
          beat_d  = '0;
          lut_d   = '0;
        end
      end
      S_LOAD: begin
        if (bus.cfg_valid) begin
          if (beat_q < BW'(B)) begin
            mask_we = 1'b1;
            beat_d  = beat_q + 1'b1;
          end else begin
            mode_d[lut_q] = bus.cfg_data[0];
            beat_d        = '0;
            if (lut_q == LW'(NUM_LUTS - 1)) begin
              state_d = S_DONE;
              lut_d   = '0;
            end else begin
              lut_d = lut_q + 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d == S_LOAD);
    done_d = (state_d == S_DONE);
  end

  always_comb begin
    lut_comb_w = '0;
    if (done_q) begin
      for (int unsigned i = 0; i < NUM_LUTS; i++) begin
        lut_comb_w[i] = mask_q[i][bus.rd_addr[i*K +: K]];
      end
    end
  end

  // Capture only while staying in DONE so a reload blanks lut_reg on the very next cycle.
  always_comb begin
    lut_reg_d = done_d ? lut_comb_w : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      lut_q     <= '0;
      mode_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lut_reg_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      lut_q     <= lut_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lut_reg_q <= lut_reg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && mask_we) begin
      for (int unsigned b = 0; b < CFG_W; b++) begin
        mask_q[lut_q][K'(int'(beat_q) * CFG_W + b)] <= bus.cfg_data[b];
      end
    end
  end

  assign bus.cfg_ready = (state_q == S_LOAD);
  assign bus.cfg_busy  = busy_q;
  assign bus.cfg_done  = done_q;
  assign bus.lut_comb  = lut_comb_w;
  assign bus.lut_reg   = lut_reg_q;
  assign bus.lut_out   = (mode_q & lut_reg_q) | (~mode_q & lut_comb_w);

endmodule
